// File: rtl/lut_sweep_if.sv
//----------------------------------------------------------------------
// Module   : lut_sweep_if
// Purpose  : Bundles the configuration, evaluate and sweep signals of
//            the LUT sweep engine. The slave side is the engine, the
//            master side is whoever drives it.
// Revision : 1.0
//----------------------------------------------------------------------
`default_nettype none

interface lut_sweep_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4
) ();
    // truth-table configuration
    logic                        cfg_we;
    logic [N_IN-1:0]             cfg_addr;
    logic [N_OUT-1:0]            cfg_data;
    // single-vector evaluation
    logic                        eval_vld;
    logic [N_IN-1:0]             eval_in;
    logic [N_OUT-1:0]            eval_out;
    logic                        eval_out_vld;
    // exhaustive sweep
    logic                        start;
    logic                        busy;
    logic                        row_vld;
    logic [N_IN-1:0]             row_idx;
    logic [N_OUT-1:0]            row_data;
    logic [N_OUT*(N_IN+1)-1:0]   ones_cnt;
    logic                        done;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, eval_vld, eval_in, start,
        output eval_out, eval_out_vld, busy, row_vld, row_idx, row_data,
               ones_cnt, done
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, eval_vld, eval_in, start,
        input  eval_out, eval_out_vld, busy, row_vld, row_idx, row_data,
               ones_cnt, done
    );
endinterface

`default_nettype wire

// File: rtl/lut_sweep_engine.sv
//----------------------------------------------------------------------
// Module   : lut_sweep_engine
// Purpose  : Programmable N_OUT-function truth table over N_IN inputs.
//            Supports single-vector evaluation with one cycle latency
//            and an exhaustive sweep that streams every row and counts
//            the ones of each function.
// Revision : 1.0
//----------------------------------------------------------------------
`default_nettype none

module lut_sweep_engine #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    lut_sweep_if.slave    bus
);
    localparam int ROWS = 1 << N_IN;
    localparam int CW   = N_IN + 1;   // one extra bit so 2^N_IN fits

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [N_IN-1:0]     idx;
    logic [N_OUT-1:0]    lut [ROWS];
    logic [CW-1:0]       cnt [N_OUT];
    logic                busy;
    logic                row_vld;
    logic [N_IN-1:0]     row_idx;
    logic [N_OUT-1:0]    row_data;
    logic                done;
    logic [N_OUT-1:0]    eval_out;
    logic                eval_out_vld;
    logic [N_OUT*CW-1:0] ones_packed;

    // Truth-table storage; writes are locked out while a sweep is visible
    // as busy so the streamed rows stay consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                lut[r] <= '0;
            end
        end else if (bus.cfg_we && !busy) begin
            lut[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Single-vector evaluate; the non-blocking read returns the row value
    // from before any write at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_out     <= '0;
            eval_out_vld <= 1'b0;
        end else begin
            eval_out_vld <= bus.eval_vld;
            if (bus.eval_vld) begin
                eval_out <= lut[bus.eval_in];
            end
        end
    end

    // Sweep controller: streams one row per cycle, accumulates per-function
    // ones counts, then spends one cycle raising done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            row_vld  <= 1'b0;
            row_idx  <= '0;
            row_data <= '0;
            done     <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    row_vld <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    idx     <= '0;
                    // busy still high here means the done cycle is being
                    // shown, so a start in that cycle is ignored as well
                    if (bus.start && !busy) begin
                        state <= SWEEP;
                        busy  <= 1'b1;
                        for (int k = 0; k < N_OUT; k++) begin
                            cnt[k] <= '0;
                        end
                    end
                end
                SWEEP: begin
                    row_vld  <= 1'b1;
                    row_idx  <= idx;
                    row_data <= lut[idx];
                    for (int k = 0; k < N_OUT; k++) begin
                        cnt[k] <= cnt[k] + {{N_IN{1'b0}}, lut[idx][k]};
                    end
                    idx <= idx + 1'b1;
                    if (idx == {N_IN{1'b1}}) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    row_vld <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Flatten the per-function counters into the packed output bus.
    always_comb begin
        ones_packed = '0;
        for (int k = 0; k < N_OUT; k++) begin
            ones_packed[k*CW +: CW] = cnt[k];
        end
    end

    assign bus.busy         = busy;
    assign bus.row_vld      = row_vld;
    assign bus.row_idx      = row_idx;
    assign bus.row_data     = row_data;
    assign bus.done         = done;
    assign bus.ones_cnt     = ones_packed;
    assign bus.eval_out     = eval_out;
    assign bus.eval_out_vld = eval_out_vld;

endmodule

`default_nettype wire
